// File: rtl/pj_dmem_responder_if.sv
// Data-memory port bundle between the core (master) and the responder (slave).
// Carries the write strobe/address/data, the read request/address/data and the
// console byte stream (valid/data out of the responder, ready back into it).
interface pj_dmem_responder_if #(
    parameter int WORD_SIZE_P = 16
);
    logic                   w_v_i;
    logic [WORD_SIZE_P-1:0] w_addr_i;
    logic [WORD_SIZE_P-1:0] w_data_i;
    logic                   r_v_i;
    logic [WORD_SIZE_P-1:0] r_addr_i;
    logic [WORD_SIZE_P-1:0] r_data_o;
    logic                   tx_v_o;
    logic [7:0]             tx_data_o;
    logic                   tx_ready_i;

    modport master (
        output w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i, tx_ready_i,
        input  r_data_o, tx_v_o, tx_data_o
    );

    modport slave (
        input  w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i, tx_ready_i,
        output r_data_o, tx_v_o, tx_data_o
    );
endinterface

// File: rtl/pj_dmem_responder.sv
// Data-memory responder: word storage plus console TX FIFO / status MMIO at the top 4 words.
// Latency: read data registered, valid the cycle after r_v_i; TX push to empty shows tx_v_o next cycle.
// Backpressure: tx_ready_i stalls the FIFO; a push into a full FIFO with no pop is dropped and sets sticky overflow.
//
// Ports: clk_i, reset_n_i (async active-low); bus (slave modport) carries w_v_i/w_addr_i/w_data_i,
// r_v_i/r_addr_i/r_data_o and the tx_v_o/tx_data_o/tx_ready_i byte stream.
// Optional macro PJ_DMEM_CYCLE_CTR_EN adds a free-running 2*WORD_SIZE_P-bit cycle counter at CYCLO/CYCHI.
module pj_dmem_responder #(
    parameter int WORD_SIZE_P  = 16,
    parameter int ELS_P        = 2**WORD_SIZE_P - 4,
    parameter int FIFO_DEPTH_P = 8
) (
    input logic                  clk_i,
    input logic                  reset_n_i,
    pj_dmem_responder_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH_P);
    localparam int CW = PW + 1;
    localparam int AW = (ELS_P > 1) ? $clog2(ELS_P) : 1;

    // MMIO block occupies the last four word addresses.
    localparam logic [WORD_SIZE_P-1:0] ADDR_TX = ~WORD_SIZE_P'(3);
    localparam logic [WORD_SIZE_P-1:0] ADDR_ST = ~WORD_SIZE_P'(2);
`ifdef PJ_DMEM_CYCLE_CTR_EN
    localparam logic [WORD_SIZE_P-1:0] ADDR_CYCLO = ~WORD_SIZE_P'(1);
    localparam logic [WORD_SIZE_P-1:0] ADDR_CYCHI = ~WORD_SIZE_P'(0);
`endif

    // Storage: never reset, contents survive reset_n_i.
    logic [WORD_SIZE_P-1:0] mem_q [ELS_P];

    logic [7:0]             fifo_q [FIFO_DEPTH_P];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic [WORD_SIZE_P-1:0] r_data_q, r_data_d;

    logic w_store, push_req, push_ok, pop, full, empty, st_rd;
    logic [WORD_SIZE_P-1:0] status;

`ifdef PJ_DMEM_CYCLE_CTR_EN
    logic [2*WORD_SIZE_P-1:0] cyc_q;
    logic [WORD_SIZE_P-1:0]   shadow_q;
`endif

    assign full  = (count_q == CW'(FIFO_DEPTH_P));
    assign empty = (count_q == '0);

    // tx_v_o comes straight from the registered count so reset drops it asynchronously.
    assign bus.tx_v_o    = !empty;
    assign bus.tx_data_o = tx_data_q;
    assign bus.r_data_o  = r_data_q;

    assign w_store  = bus.w_v_i && (bus.w_addr_i < WORD_SIZE_P'(ELS_P));
    assign push_req = bus.w_v_i && (bus.w_addr_i == ADDR_TX);
    assign pop      = bus.tx_v_o && bus.tx_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign st_rd    = bus.r_v_i && (bus.r_addr_i == ADDR_ST);

    always_comb begin
        status             = '0;
        status[0]          = full;
        status[1]          = empty;
        status[2]          = ovf_q;
        status[3 +: CW]    = count_q;
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q + PW'(push_ok);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        count_d   = count_q + CW'(push_ok) - CW'(pop);
        // An overflow in the same cycle as a STATUS read wins over the clear.
        ovf_d     = (push_req && !push_ok) ? 1'b1 : (st_rd ? 1'b0 : ovf_q);

        // Next head byte: bypass the pushed byte when it lands in an otherwise empty FIFO.
        tx_data_d = tx_data_q;
        if (count_d != '0) begin
            if (push_ok && (count_q == CW'(pop))) begin
                tx_data_d = bus.w_data_i[7:0];
            end else begin
                tx_data_d = fifo_q[rd_ptr_d];
            end
        end

        r_data_d = r_data_q;
        if (bus.r_v_i) begin
            if (bus.r_addr_i < WORD_SIZE_P'(ELS_P)) begin
                r_data_d = mem_q[bus.r_addr_i[AW-1:0]];
            end else if (bus.r_addr_i == ADDR_ST) begin
                r_data_d = status;
`ifdef PJ_DMEM_CYCLE_CTR_EN
            end else if (bus.r_addr_i == ADDR_CYCLO) begin
                r_data_d = cyc_q[WORD_SIZE_P-1:0];
            end else if (bus.r_addr_i == ADDR_CYCHI) begin
                r_data_d = shadow_q;
`endif
            end else begin
                r_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            mem_q[bus.w_addr_i[AW-1:0]] <= bus.w_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < FIFO_DEPTH_P; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            tx_data_q <= '0;
            r_data_q  <= '0;
        end else begin
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= bus.w_data_i[7:0];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            tx_data_q <= tx_data_d;
            r_data_q  <= r_data_d;
        end
    end

`ifdef PJ_DMEM_CYCLE_CTR_EN
    // Reading CYCLO latches the high half so a following CYCHI read is coherent.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cyc_q    <= '0;
            shadow_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (bus.r_v_i && (bus.r_addr_i == ADDR_CYCLO)) begin
                shadow_q <= cyc_q[2*WORD_SIZE_P-1:WORD_SIZE_P];
            end
        end
    end
`endif
endmodule

// File: doc/pj_dmem_responder.md
Name: pj_dmem_responder

Overview:
- Responder end of the core's data-memory port: it accepts the core's write strobes and synchronous read requests and returns read data one cycle later.
- Most of the address space maps to word storage.
- The top four word addresses are memory-mapped I/O: a console transmit FIFO drained by a valid/ready byte stream, plus a status register.
- Sits beside the core in the top level in place of a bare synchronous RAM.

Parameters:
- WORD_SIZE_P, 16, data and address width in bits.
- ELS_P, 2**WORD_SIZE_P - 4, number of storage words; must not exceed 2**WORD_SIZE_P - 4.
- FIFO_DEPTH_P, 8, console FIFO entries; must be a power of two and at least 2.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- w_v_i  in  1  write strobe.
- w_addr_i  in  WORD_SIZE_P  write word address.
- w_data_i  in  WORD_SIZE_P  write data.
- r_v_i  in  1  read request.
- r_addr_i  in  WORD_SIZE_P  read word address.
- r_data_o  out  WORD_SIZE_P  read data, valid the cycle after r_v_i.
- tx_v_o  out  1  console byte valid.
- tx_data_o  out  8  console byte.
- tx_ready_i  in  1  sink accepts the byte when tx_v_o & tx_ready_i.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled at the top level):
  - r_data_o = 0, tx_v_o = 0, tx_data_o = 0.
  - FIFO pointers and count = 0, overflow flag = 0, cycle counter = 0.
  - Storage contents are not cleared.
- Address map; MMIO base M = 2**WORD_SIZE_P - 4:
  - Addresses below ELS_P: storage.
  - M+0 TXDATA: write pushes w_data_i[7:0]; read returns 0.
  - M+1 STATUS, read-only:
    - bit0 full, bit1 empty, bit2 overflow.
    - bits[3+:log2(FIFO_DEPTH_P)+1] count; other bits 0.
    - A read clears overflow.
  - M+2 CYCLO, M+3 CYCHI: see Optional Feature.
  - Addresses from ELS_P up to M-1: writes ignored, reads return 0.
- Read latency is exactly 1 cycle:
  - r_data_o is registered and updates only in cycles following r_v_i = 1.
  - Otherwise r_data_o holds its previous value.
- Simultaneous read and write to the same storage address: the read returns the old contents (read-before-write).
- Write and read in the same cycle to different addresses are both performed.
- FIFO push on a TXDATA write:
  - If the FIFO is full and no pop happens that cycle, the byte is dropped and overflow is set (sticky).
  - If full and a pop happens the same cycle, the push is accepted and count stays at FIFO_DEPTH_P.
- FIFO pop on tx_v_o & tx_ready_i:
  - tx_v_o = !empty; tx_data_o = head entry (registered output, first-word-fall-through).
  - tx_data_o holds steady while tx_v_o & !tx_ready_i.
- Push to an empty FIFO: tx_v_o rises the next cycle.
- Pointers wrap modulo FIFO_DEPTH_P. Count width is log2(FIFO_DEPTH_P)+1.
- STATUS read in the same cycle as an overflow event:
  - r_data_o reports the pre-event value (bit2 as it was before the cycle).
  - Overflow ends set: the set takes priority over the clear.
- STATUS reports the count as registered before that cycle's push or pop.
- Reset asserted mid-transfer: FIFO contents are discarded and tx_v_o drops immediately (asynchronously).

Optional Feature:
- Macro PJ_DMEM_CYCLE_CTR_EN.
- Defined:
  - A 2*WORD_SIZE_P-bit free-running counter increments every cycle after reset and wraps to 0.
  - CYCLO returns the low half and snapshots the high half into a shadow register.
  - CYCHI returns the shadow, giving a coherent 32-bit value when CYCLO is read first.
  - Writes to CYCLO/CYCHI are ignored.
- Undefined: CYCLO and CYCHI read 0; no counter or shadow logic is synthesized.

Test Plan:
- Storage round trip: write 0x1234 to 0x0010, then r_v_i at 0x0010 next cycle -> r_data_o = 0x1234 one cycle after r_v_i; holds while r_v_i = 0.
- Same-address read and write: storage 0x0020 = 0xAAAA; same cycle w 0x5555 and r 0x0020 -> r_data_o = 0xAAAA; reread -> 0x5555.
- Console stream with tx_ready_i = 1:
  - Write 0x41, 0x42, 0x43 to 0xFFFC on consecutive cycles.
  - Required: tx bytes 0x41, 0x42, 0x43 in order, tx_v_o first high one cycle after the first write.
  - STATUS afterwards reads 0x0002 (empty).
- Backpressure and overflow with tx_ready_i = 0:
  - Push 9 bytes. STATUS reads bit0 = 1, bit2 = 1, count = 8 (0x0045).
  - A second STATUS read shows bit2 = 0.
  - Releasing ready drains exactly the first 8 bytes.
- Full with simultaneous pop: FIFO at 8 entries, push 0x7E in the same cycle as a pop -> accepted, count stays 8, 0x7E emerges last, no overflow.
- Async reset: assert reset_n_i = 0 mid-drain between clock edges -> tx_v_o = 0 and r_data_o = 0 immediately; after release STATUS = 0x0002 and earlier storage writes are still readable.
